error_capture_unit: RTL and testbench

Parametrised successor to the processor's sticky error flag. It samples decode-stage and execute-stage fault sources and classifies each fault by cause. It captures the first fault's cause, opcode index and PC, raises a halt request, and holds until an explicit clear. It also keeps a saturating count of every fault event for the debug interface.

---
 rtl/error_capture_pkg.sv | 18 +
 rtl/error_capture_lowest_set_index.sv | 26 ++
 rtl/error_capture_unit.sv | 135 +++++++++++++
 tb/tb_error_capture_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/error_capture_pkg.sv
// error_capture_pkg
// Shared definitions for the error capture unit:
//   - cause codes reported on error_cause
//   - FSM state type for the RUN/FAULT controller
package error_capture_pkg;

    localparam logic [2:0] CAUSE_NONE         = 3'd0;
    localparam logic [2:0] CAUSE_DECODE       = 3'd1;
    localparam logic [2:0] CAUSE_MULTI_SELECT = 3'd2;
    localparam logic [2:0] CAUSE_EXEC         = 3'd3;
    localparam logic [2:0] CAUSE_NO_SELECT    = 3'd4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } ecu_state_t;

endpackage : error_capture_pkg

// File: rtl/error_capture_lowest_set_index.sv
// lowest_set_index
// Priority encoder: index of the lowest set bit of vec, plus a valid flag.
// Ports:
//   vec   in  WIDTH  bits to encode
//   idx   out IDX_W  index of lowest set bit (0 when no bit set)
//   valid out 1      at least one bit of vec is set
module lowest_set_index #(
    parameter int WIDTH = 11,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

    assign valid = |vec;

endmodule : lowest_set_index

// File: rtl/error_capture_unit.sv
// error_capture_unit
// Samples decode/execute fault sources, classifies each fault by cause,
// captures the first fault (cause, opcode index, pc) and holds it with a
// halt request until error_clear. Counts every fault event (saturating).
// Optional feature macro: ERROR_NO_OPCODE_CHECK_EN -- an all-zero opcode
// selection in the execute stage becomes a NO_SELECT fault.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   current_pipeline_stage    stage of the multi-cycle pipeline
//   id_opcode_decoding_error  illegal instruction from decode
//   ex_opcode_selection       one-hot unit select
//   ex_errors                 per-unit error flags
//   pc                        PC of the instruction in flight
//   error_clear               releases a held fault
//   error, halt_request       high while a fault is held
//   error_cause               captured cause code
//   error_opcode_index        captured failing unit index (EXEC only)
//   error_pc                  captured PC
//   error_count               saturating fault event count
module error_capture_unit
    import error_capture_pkg::*;
#(
    parameter int NUM_OPCODES   = 11,
    parameter int STAGE_W       = 2,
    parameter int DECODE_STAGE  = 2,
    parameter int EXECUTE_STAGE = 3,
    parameter int COUNT_W       = 8,
    localparam int IDX_W = (NUM_OPCODES > 1) ? $clog2(NUM_OPCODES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STAGE_W-1:0]     current_pipeline_stage,
    input  logic                   id_opcode_decoding_error,
    input  logic [NUM_OPCODES-1:0] ex_opcode_selection,
    input  logic [NUM_OPCODES-1:0] ex_errors,
    input  logic [31:0]            pc,
    input  logic                   error_clear,
    output logic                   error,
    output logic                   halt_request,
    output logic [2:0]             error_cause,
    output logic [IDX_W-1:0]       error_opcode_index,
    output logic [31:0]            error_pc,
    output logic [COUNT_W-1:0]     error_count
);

    ecu_state_t       state_q, state_d;
    logic [2:0]       cause;
    logic             fault_evt;
    logic             capture, zero_fields;
    logic             multi_sel, exec_hit;
    logic [IDX_W-1:0] exec_idx;

    wire in_decode  = (current_pipeline_stage == STAGE_W'(DECODE_STAGE));
    wire in_execute = (current_pipeline_stage == STAGE_W'(EXECUTE_STAGE));

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_sel = |((ex_opcode_selection - NUM_OPCODES'(1)) & ex_opcode_selection);

    lowest_set_index #(.WIDTH(NUM_OPCODES), .IDX_W(IDX_W)) u_lsi (
        .vec   (ex_errors & ex_opcode_selection),
        .idx   (exec_idx),
        .valid (exec_hit)
    );

    always_comb begin
        cause = CAUSE_NONE;
        if (in_decode && id_opcode_decoding_error) begin
            cause = CAUSE_DECODE;
        end else if (in_execute) begin
            if (multi_sel)     cause = CAUSE_MULTI_SELECT;
            else if (exec_hit) cause = CAUSE_EXEC;
`ifdef ERROR_NO_OPCODE_CHECK_EN
            else if (ex_opcode_selection == '0) cause = CAUSE_NO_SELECT;
`endif
        end
    end

    assign fault_evt = (cause != CAUSE_NONE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // A clear that coincides with a new event re-captures instead of dropping it.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        zero_fields = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (fault_evt) begin
                    state_d = ST_FAULT;
                    capture = 1'b1;
                end
            end
            ST_FAULT: begin
                if (error_clear) begin
                    if (fault_evt) begin
                        capture = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        zero_fields = 1'b1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            error_cause        <= CAUSE_NONE;
            error_opcode_index <= '0;
            error_pc           <= '0;
        end else if (capture) begin
            error_cause        <= cause;
            error_opcode_index <= (cause == CAUSE_EXEC) ? exec_idx : '0;
            error_pc           <= pc;
        end else if (zero_fields) begin
            error_cause        <= CAUSE_NONE;
            error_opcode_index <= '0;
            error_pc           <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                 error_count <= '0;
        else if (fault_evt && (error_count != '1)) error_count <= error_count + COUNT_W'(1);
    end

    assign error        = (state_q == ST_FAULT);
    assign halt_request = (state_q == ST_FAULT);

endmodule : error_capture_unit

// File: tb/tb_error_capture_unit.sv
// tb_error_capture_unit
// Scoreboard bench: each driven cycle pushes the reference model's expected
// outputs; after the clock edge the entry is popped and compared against two
// instances (COUNT_W=8 and COUNT_W=2) sharing the same stimulus.
module tb_error_capture_unit;

    localparam int N = 11;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  stage;
    logic        dec_err;
    logic [N-1:0] sel, errs;
    logic [31:0] pc;
    logic        clr;

    logic        err_a, halt_a, err_b, halt_b;
    logic [2:0]  cause_a, cause_b;
    logic [3:0]  idx_a, idx_b;
    logic [31:0] pc_a, pc_b;
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    error_capture_unit dut (
        .clk(clk), .rst(rst), .current_pipeline_stage(stage),
        .id_opcode_decoding_error(dec_err), .ex_opcode_selection(sel),
        .ex_errors(errs), .pc(pc), .error_clear(clr),
        .error(err_a), .halt_request(halt_a), .error_cause(cause_a),
        .error_opcode_index(idx_a), .error_pc(pc_a), .error_count(cnt_a)
    );

    error_capture_unit #(.COUNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .current_pipeline_stage(stage),
        .id_opcode_decoding_error(dec_err), .ex_opcode_selection(sel),
        .ex_errors(errs), .pc(pc), .error_clear(clr),
        .error(err_b), .halt_request(halt_b), .error_cause(cause_b),
        .error_opcode_index(idx_b), .error_pc(pc_b), .error_count(cnt_b)
    );

    typedef struct {
        logic        flt;
        logic [2:0]  cause;
        logic [3:0]  idx;
        logic [31:0] pc;
        logic [7:0]  c8;
        logic [1:0]  c2;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_cause(input logic [1:0] s, input logic d,
                                             input logic [N-1:0] sl, input logic [N-1:0] e);
        if (s == 2'd2 && d) return 3'd1;
        if (s == 2'd3) begin
            if ($countones(sl) > 1) return 3'd2;
            if ((sl & e) != '0)     return 3'd3;
`ifdef ERROR_NO_OPCODE_CHECK_EN
            if (sl == '0)           return 3'd4;
`endif
        end
        return 3'd0;
    endfunction

    function automatic logic [3:0] ref_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return 4'(i);
        return 4'd0;
    endfunction

    // Advance the model by one edge, then drive, clock and compare.
    task automatic step(input logic r, input logic [1:0] s, input logic d,
                        input logic [N-1:0] sl, input logic [N-1:0] e,
                        input logic [31:0] p, input logic c);
        logic [2:0] cs;
        exp_t got;
        @(negedge clk);
        rst = r; stage = s; dec_err = d; sel = sl; errs = e; pc = p; clr = c;
        cs = ref_cause(s, d, sl, e);
        if (r) begin
            m = '{1'b0, 3'd0, 4'd0, 32'd0, 8'd0, 2'd0};
        end else begin
            if (cs != 0) begin
                if (m.c8 != 8'hFF) m.c8++;
                if (m.c2 != 2'd3)  m.c2++;
            end
            if (cs != 0 && (!m.flt || c)) begin
                m.flt = 1'b1; m.cause = cs; m.pc = p;
                m.idx = (cs == 3'd3) ? ref_idx(sl & e) : 4'd0;
            end else if (m.flt && c) begin
                m = '{1'b0, 3'd0, 4'd0, 32'd0, m.c8, m.c2};
            end
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        chk("sb_depth", sb.size(), 1);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            chk("error",      err_a,   got.flt);
            chk("halt",       halt_a,  got.flt);
            chk("cause",      cause_a, got.cause);
            chk("index",      idx_a,   got.idx);
            chk("pc",         pc_a,    got.pc);
            chk("count8",     cnt_a,   got.c8);
            chk("c2_error",   err_b,   got.flt);
            chk("c2_halt",    halt_b,  got.flt);
            chk("c2_cause",   cause_b, got.cause);
            chk("c2_index",   idx_b,   got.idx);
            chk("c2_pc",      pc_b,    got.pc);
            chk("count2_sat", cnt_b,   got.c2);
        end
    endtask

    initial begin
        logic [N-1:0] rs, re;
        m = '{1'b0, 3'd0, 4'd0, 32'd0, 8'd0, 2'd0};
        rst = 1'b1; stage = '0; dec_err = 1'b0; sel = '0; errs = '0; pc = '0; clr = 1'b0;

        // reset, then directed cases
        step(1, 0, 0, 11'b0,   11'b0,   32'h0,    0);
        step(0, 0, 0, 11'b0,   11'b0,   32'h0,    0);
        step(0, 2, 1, 11'b0,   11'b0,   32'h100,  0);   // decode fault
        step(0, 0, 0, 11'b0,   11'b0,   32'h104,  1);   // clear, no event
        step(0, 3, 0, 11'b100, 11'b100, 32'h200,  0);   // exec idx 2
        step(0, 3, 0, 11'b101, 11'b0,   32'h204,  0);   // multi: counted only
        step(0, 3, 0, 11'b011, 11'b001, 32'h300,  1);   // clear + event: overwrite
        step(0, 0, 0, 11'b0,   11'b0,   32'h0,    1);
        step(0, 3, 0, 11'b011, 11'b001, 32'h308,  0);   // multi beats exec
        step(0, 2, 1, 11'b0,   11'b0,   32'h400,  1);   // clear + decode
        step(0, 1, 1, 11'b110, 11'b110, 32'h500,  0);   // other stage: no event
        step(0, 2, 0, 11'b110, 11'b110, 32'h504,  0);   // exec signals ignored in decode stage
        step(0, 0, 0, 11'b0,   11'b0,   32'h0,    1);
        step(0, 3, 0, 11'b0,   11'b111, 32'h600,  0);   // empty select
        step(0, 0, 0, 11'b0,   11'b0,   32'h0,    1);
        step(0, 3, 0, 11'h400, 11'h7FF, 32'h700,  0);   // top unit
        step(0, 0, 0, 11'b0,   11'b0,   32'h0,    0);
        step(1, 3, 0, 11'b1,   11'b1,   32'h800,  1);   // rst beats event
        step(0, 0, 0, 11'b0,   11'b0,   32'h0,    0);

        // random traffic, biased towards legal one-hot selects
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: rs = '0;
                1: rs = N'($urandom);
                default: rs = N'(1) << $urandom_range(0, N - 1);
            endcase
            re = ($urandom_range(0, 1) != 0) ? N'($urandom) : '0;
            step(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), rs, re, $urandom,
                 ($urandom_range(0, 3) == 0));
        end

        step(1, 2, 1, 11'b0, 11'b0, 32'h900, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_error_capture_unit
